soc_system_led_pio_arbiter: RTL
===============================

// Module: soc_system_led_pio_arbiter
// PURPOSE
//  Two-port arbiter sharing the single LED PIO Avalon-MM slave between the HPS lightweight bridge (m0)
//  and the GPU status master (m1). Serialises accesses round-robin, drives the PIO chipselect/write_n
//  strobes, and returns PIO readdata to the owning requester with a readdatavalid pulse.
//  Sits between the two masters and the PIO instance inside soc_system.
// PARAMETERS
//  ADDR_W        2   PIO register address width
//  DATA_W        32  data width, both sides
//  READ_LATENCY  1   cycles from PIO address/chipselect to valid pio_readdata (legal 1..3)
// PORTS
//  clk              in   1       system clock; only clock
//  reset            in   1       synchronous, active-high reset
//  m0_address       in   ADDR_W  requester 0 register address
//  m0_read          in   1       requester 0 read request
//  m0_write         in   1       requester 0 write request
//  m0_writedata     in   DATA_W  requester 0 write data
//  m0_waitrequest   out  1       low for exactly the accept cycle of an m0 command
//  m0_readdata      out  DATA_W  read return data for m0
//  m0_readdatavalid out  1       one-cycle pulse qualifying m0_readdata
//  m1_*             --   --      identical set for requester 1
//  pio_address      out  ADDR_W  to PIO address
//  pio_chipselect   out  1       to PIO chipselect
//  pio_write_n      out  1       to PIO write_n (active-low)
//  pio_writedata    out  DATA_W  to PIO writedata
//  pio_readdata     in   DATA_W  from PIO readdata
// BEHAVIOUR
//  All outputs are registered. Reset values: waitrequests 1, readdatavalids 0, readdata 0,
//   pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, FSM IDLE, last_grant=1.
//  FSM: IDLE -> ISSUE -> (write) IDLE | (read) RWAIT -> IDLE.
//  IDLE: sample requests (req = read|write). If none, stay. If one, grant it. If both, grant the
//   one != last_grant; update last_grant. Latch address, writedata, and op into the PIO regs. -> ISSUE.
//  ISSUE (1 cycle): pio_chipselect=1; pio_write_n=0 for a write, else 1; granted mN_waitrequest=0
//   (command accepted), the other stays 1. Write -> IDLE. Read -> RWAIT with count=READ_LATENCY.
//  RWAIT: decrement count; when it reaches 0, capture pio_readdata into mN_readdata, pulse
//   mN_readdatavalid for 1 cycle, -> IDLE. Strobes are deasserted (chipselect 0, write_n 1)
//   outside ISSUE; pio_address holds its last value.
//  Timing (READ_LATENCY=1): request seen in cycle T -> accept/strobe T+1 -> readdatavalid T+3.
//   Write: 2 cycles per access; back-to-back alternation gives 1 PIO write per 2 cycles.
//  read and write both high on one requester: write is performed, read dropped.
//  Requester deasserting before accept: latched command still issues (Avalon hold rule applies).
//  Non-granted requester sees waitrequest=1 throughout; it is served at the next IDLE if still
//   requesting (fairness: max wait one foreign access).
//  mN_readdata holds its last captured value between pulses.
//  Reset mid-operation: FSM to IDLE next cycle, all outputs to reset values; a pending read returns
//   no readdatavalid; a strobe already registered in the reset cycle is not cancelled.
// TESTING
//  1 m0 writes 0x5 to addr 0 alone -> pio_chipselect=1, write_n=0, writedata=0x5 one cycle; m0_waitrequest=0 same cycle.
//  2 m1 reads addr 0 with pio_readdata=0xA -> m1_readdatavalid pulses once with 0xA, 2 cycles after accept.
//  3 m0,m1 both write continuously from reset -> grants alternate m0,m1,m0,m1; no requester starved.
//  4 m0 write 0x3 and m1 read same cycle -> m0 accepted first; m1 readdatavalid returns 0x3-consistent data.
//  5 READ_LATENCY=3 read -> readdatavalid exactly 4 cycles after accept cycle; data captured at that point.
//  6 reset asserted during RWAIT -> no readdatavalid; all outputs at reset values next cycle; next request served normally.

Source files
------------

// File: rtl/soc_system_led_pio_arbiter.sv
// Round-robin arbiter sharing one LED PIO Avalon-MM slave between two masters.
// Every output is registered; read data returns with a one-cycle readdatavalid pulse.
module soc_system_led_pio_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t            state, state_next;
  logic [1:0]        count, count_next;
  logic              last_grant, last_grant_next;
  logic              grant, grant_next;
  logic              op_write, op_write_next;
  logic              sel;
  logic              req0, req1;
  logic [ADDR_W-1:0] address_next;
  logic [DATA_W-1:0] writedata_next;
  logic              chipselect_next, write_n_next;
  logic              wait0_next, wait1_next;
  logic              valid0_next, valid1_next;
  logic [DATA_W-1:0] rdata0_next, rdata1_next;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    state_next      = state;
    count_next      = count;
    last_grant_next = last_grant;
    grant_next      = grant;
    op_write_next   = op_write;
    sel             = 1'b0;
    address_next    = pio_address;
    writedata_next  = pio_writedata;
    chipselect_next = 1'b0;
    write_n_next    = 1'b1;
    wait0_next      = 1'b1;
    wait1_next      = 1'b1;
    valid0_next     = 1'b0;
    valid1_next     = 1'b0;
    rdata0_next     = m0_readdata;
    rdata1_next     = m1_readdata;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester that did not win last time goes first.
          sel             = (req0 && req1) ? ~last_grant : req1;
          grant_next      = sel;
          last_grant_next = sel;
          op_write_next   = sel ? m1_write : m0_write;
          address_next    = sel ? m1_address : m0_address;
          writedata_next  = sel ? m1_writedata : m0_writedata;
          chipselect_next = 1'b1;
          write_n_next    = ~op_write_next;
          wait0_next      = sel;
          wait1_next      = ~sel;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (op_write) begin
          state_next = IDLE;
        end else begin
          count_next = 2'(READ_LATENCY);
          state_next = RWAIT;
        end
      end
      RWAIT: begin
        // The final count cycle is the one in which pio_readdata is valid.
        if (count <= 2'd1) begin
          if (grant) begin
            rdata1_next = pio_readdata;
            valid1_next = 1'b1;
          end else begin
            rdata0_next = pio_readdata;
            valid0_next = 1'b1;
          end
          state_next = IDLE;
        end else begin
          count_next = count - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      count            <= '0;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      op_write         <= 1'b0;
      pio_address      <= '0;
      pio_writedata    <= '0;
      pio_chipselect   <= 1'b0;
      pio_write_n      <= 1'b1;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      last_grant       <= last_grant_next;
      grant            <= grant_next;
      op_write         <= op_write_next;
      pio_address      <= address_next;
      pio_writedata    <= writedata_next;
      pio_chipselect   <= chipselect_next;
      pio_write_n      <= write_n_next;
      m0_waitrequest   <= wait0_next;
      m1_waitrequest   <= wait1_next;
      m0_readdatavalid <= valid0_next;
      m1_readdatavalid <= valid1_next;
      m0_readdata      <= rdata0_next;
      m1_readdata      <= rdata1_next;
    end
  end

endmodule
